// File: rtl/cache_arb_pkg.sv
// Shared types for the cache port arbiter: cache command codes, FSM states
// and a helper that tells whether a command returns read data.
package cache_arb_pkg;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_RD8  = 3'd1,
        CMD_RD16 = 3'd2,
        CMD_RD32 = 3'd3,
        CMD_INV  = 3'd4,
        CMD_WR8  = 3'd5,
        CMD_WR16 = 3'd6,
        CMD_WR32 = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int DATA_W = 32;

    function automatic logic is_read(input logic [2:0] cmd);
        return (cmd == CMD_RD8) || (cmd == CMD_RD16) || (cmd == CMD_RD32);
    endfunction

endpackage

// File: rtl/cache_arb_rr.sv
// Combinational two-way round-robin picker: on a tie the master that did
// not win last time is chosen.
module cache_arb_rr (
    input  logic [1:0] i_req,
    input  logic       i_rr_last,
    output logic       o_grant,
    output logic       o_valid
);

    assign o_valid = |i_req;
    assign o_grant = (&i_req) ? ~i_rr_last : i_req[1];

endmodule

// File: rtl/cache_port_arbiter.sv
// Two-master arbiter/sequencer for the cache CPU port. Define
// CACHE_ARB_TIMEOUT_EN to add a WAIT watchdog that aborts with err = 1.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [2:0]        m0_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic [31:0]       m0_rdata,
    output logic              m0_done,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [2:0]        m1_cmd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic [31:0]       m1_rdata,
    output logic              m1_done,
    output logic              m1_err,
    output logic [2:0]        c_cmd,
    output logic [ADDR_W-1:0] c_addr,
    output logic [31:0]       c_wdata,
    input  logic [31:0]       c_rdata,
    input  logic              c_ack,
    output logic              busy,
    output logic              grant_id
);

    state_e            r_state;
    logic              r_rr_last;
    logic [2:0]        r_cmd_lat;
    logic [1:0]        w_req_vec;
    logic              w_grant;
    logic              w_valid;
    logic [2:0]        w_sel_cmd;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [31:0]       w_resp_data;

    // A request with cmd = 0 is not a request at all.
    assign w_req_vec[0] = m0_req && (m0_cmd != CMD_NONE);
    assign w_req_vec[1] = m1_req && (m1_cmd != CMD_NONE);

    cache_arb_rr u_rr (
        .i_req     (w_req_vec),
        .i_rr_last (r_rr_last),
        .o_grant   (w_grant),
        .o_valid   (w_valid)
    );

    assign w_sel_cmd   = w_grant ? m1_cmd   : m0_cmd;
    assign w_sel_addr  = w_grant ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_grant ? m1_wdata : m0_wdata;
    assign w_resp_data = is_read(r_cmd_lat) ? c_rdata : 32'd0;

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] r_wait_cnt;
`else
    logic [31:0] w_unused_cfg;
    assign w_unused_cfg = TIMEOUT_CYCLES;
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rr_last <= 1'b1;
            r_cmd_lat <= CMD_NONE;
            c_cmd     <= CMD_NONE;
            c_addr    <= '0;
            c_wdata   <= '0;
            busy      <= 1'b0;
            grant_id  <= 1'b0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
            r_wait_cnt <= '0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        c_cmd     <= w_sel_cmd;
                        c_addr    <= w_sel_addr;
                        c_wdata   <= w_sel_wdata;
                        r_cmd_lat <= w_sel_cmd;
                        grant_id  <= w_grant;
                        busy      <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef CACHE_ARB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (c_ack) begin
                        c_cmd   <= CMD_NONE;
                        r_state <= ST_RESP;
                        if (grant_id) begin
                            m1_done  <= 1'b1;
                            m1_rdata <= w_resp_data;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_rdata <= w_resp_data;
                        end
                    end
`ifdef CACHE_ARB_TIMEOUT_EN
                    else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: the cache never answered, report err with no data.
                        c_cmd   <= CMD_NONE;
                        r_state <= ST_RESP;
                        if (grant_id) begin
                            m1_done <= 1'b1;
                            m1_err  <= 1'b1;
                        end else begin
                            m0_done <= 1'b1;
                            m0_err  <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    m0_done   <= 1'b0;
                    m1_done   <= 1'b0;
                    m0_rdata  <= '0;
                    m1_rdata  <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
                    m0_err    <= 1'b0;
                    m1_err    <= 1'b0;
`endif
                    r_rr_last <= grant_id;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Randomized bench for cache_port_arbiter against a transaction-level model
// of grant order, latched command fields and response data.
module tb_cache_port_arbiter;

    localparam int AW = 18;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m1_req;
    logic [2:0]    m0_cmd, m1_cmd;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          m0_done, m1_done, m0_err, m1_err;
    logic [2:0]    c_cmd;
    logic [AW-1:0] c_addr;
    logic [31:0]   c_wdata, c_rdata;
    logic          c_ack, busy, grant_id;

    always #5 clk = ~clk;

    cache_port_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .c_cmd(c_cmd), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack), .busy(busy), .grant_id(grant_id)
    );

    int total = 0;
    int bad   = 0;
    int ntxn  = 0;

    // Model state: per-master pending request and last round-robin winner.
    logic          p_req [2];
    logic [2:0]    p_cmd [2];
    logic [AW-1:0] p_addr[2];
    logic [31:0]   p_wd  [2];
    int            last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        m0_req = p_req[0]; m0_cmd = p_cmd[0]; m0_addr = p_addr[0]; m0_wdata = p_wd[0];
        m1_req = p_req[1]; m1_cmd = p_cmd[1]; m1_addr = p_addr[1]; m1_wdata = p_wd[1];
    endtask

    function automatic bit valid(input int m);
        return p_req[m] && (p_cmd[m] != 3'd0);
    endfunction

    function automatic bit reads(input logic [2:0] cmd);
        return (cmd >= 3'd1) && (cmd <= 3'd3);
    endfunction

    task automatic new_req(input int m);
        int r;
        r = $urandom_range(0, 3);
        p_req[m]  = (r != 0);
        p_cmd[m]  = (r >= 2) ? 3'($urandom_range(1, 7)) : 3'd0;
        p_addr[m] = AW'($urandom);
        p_wd[m]   = $urandom;
    endtask

    task automatic run_rounds(input int n);
        int w, d;
        logic [31:0] rd, exp_rd;
        logic [1:0]  dn;
        for (int i = 0; i < n; i++) begin
            for (int m = 0; m < 2; m++) if (!valid(m)) new_req(m);
            drive();
            check("idle_busy", busy, 0);
            if (!valid(0) && !valid(1)) begin
                tick();
                check("noreq_busy", busy, 0);
                check("noreq_ccmd", c_cmd, 0);
                continue;
            end
            w = (valid(0) && valid(1)) ? 1 - last : (valid(0) ? 0 : 1);
            tick();
            check("issue_cmd", c_cmd, p_cmd[w]);
            check("issue_addr", c_addr, p_addr[w]);
            check("issue_wdata", c_wdata, p_wd[w]);
            check("issue_grant", grant_id, w);
            check("issue_busy", busy, 1);
            c_ack   = 1'($urandom_range(0, 1));
            c_rdata = $urandom;
            tick();
            c_ack = 1'b0;
            d = $urandom_range(0, 4);
            for (int k = 0; k < d; k++) begin
                check("wait_cmd", c_cmd, p_cmd[w]);
                check("wait_addr", c_addr, p_addr[w]);
                check("wait_done", {m1_done, m0_done}, 0);
                if (valid(1 - w)) begin
                    p_addr[1 - w] = AW'($urandom);
                    p_wd[1 - w]   = $urandom;
                    drive();
                end
                tick();
            end
            rd      = $urandom;
            c_ack   = 1'b1;
            c_rdata = rd;
            tick();
            c_ack   = 1'b0;
            c_rdata = $urandom;
            exp_rd  = reads(p_cmd[w]) ? rd : 32'd0;
            dn      = 2'b00;
            dn[w]   = 1'b1;
            check("resp_done", {m1_done, m0_done}, dn);
            check("resp_rdata", w ? m1_rdata : m0_rdata, exp_rd);
            check("resp_err", {m1_err, m0_err}, 0);
            check("resp_ccmd", c_cmd, 0);
            $display("txn %0d: m%0d cmd=%0d addr=0x%05h rdata=0x%08h", ntxn, w, p_cmd[w], p_addr[w], exp_rd);
            ntxn++;
            last = w;
            new_req(w);
            drive();
            tick();
            check("post_done", {m1_done, m0_done}, 0);
            check("post_busy", busy, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        c_ack = 1'b0;
        c_rdata = '0;
        for (int m = 0; m < 2; m++) begin
            p_req[m] = 0; p_cmd[m] = 0; p_addr[m] = 0; p_wd[m] = 0;
        end
        drive();
        last = 1;
        #12;
        check("rst_ccmd", c_cmd, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_done", {m1_done, m0_done}, 0);
        check("rst_rdata", {m1_rdata, m0_rdata}, 0);
        reset = 1'b0;

        // Simultaneous requests right after reset: m0 must win first.
        p_req[0] = 1; p_cmd[0] = 3'd3; p_addr[0] = 18'h00010; p_wd[0] = 0;
        p_req[1] = 1; p_cmd[1] = 3'd6; p_addr[1] = 18'h3FFF2; p_wd[1] = 32'h0000BEEF;
        run_rounds(80);

        // Reset in WAIT drops the transaction without a done.
        p_req[0] = 1; p_cmd[0] = 3'd3; p_addr[0] = 18'h00010;
        p_req[1] = 0; p_cmd[1] = 3'd0;
        drive();
        tick();
        tick();
        check("prerst_ccmd", c_cmd, 3);
        reset = 1'b1;
        #1;
        check("midrst_ccmd", c_cmd, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", {m1_done, m0_done}, 0);
        #1;
        reset = 1'b0;
        last = 1;
        run_rounds(20);

`ifdef CACHE_ARB_TIMEOUT_EN
        p_req[0] = 0; p_cmd[0] = 3'd0;
        p_req[1] = 1; p_cmd[1] = 3'd1; p_addr[1] = 18'h01230;
        drive();
        tick();
        tick();
        for (int k = 0; k < TO; k++) begin
            check("to_wait_done", {m1_done, m0_done}, 0);
            tick();
        end
        check("to_done", {m1_done, m0_done}, 2'b10);
        check("to_err", {m1_err, m0_err}, 2'b10);
        check("to_rdata", m1_rdata, 0);
        last = 1;
        new_req(1);
        drive();
        tick();
        run_rounds(10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-master arbiter and sequencer for the CPU-side port of the 2-way set-associative cache. Accepts independent requests from two masters (m0 = instruction fetch, m1 = load/store), grants one at a time with round-robin fairness, and holds the cache command and address stable for the whole transaction. Returns read data and a one-cycle completion pulse to the winning master. Sits between the core's fetch/LSU units and the cache, converting a req/done handshake into the cache's one-command-per-transaction protocol.

## Interface
- TIMEOUT_CYCLES, 255: watchdog limit in cycles spent waiting for `c_ack`; used only with `CACHE_ARB_TIMEOUT_EN`.
- ADDR_W, 18: byte address width (14-bit line address plus 4-bit offset).
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- m0_req / m1_req  in  1  request; held high with stable cmd/addr/wdata until matching done.
- m0_cmd / m1_cmd  in  3  0 none, 1/2/3 read 8/16/32, 4 invalidate line, 5/6/7 write 8/16/32.
- m0_addr / m1_addr  in  ADDR_W  byte address.
- m0_wdata / m1_wdata  in  32  write data, LSB-aligned.
- m0_rdata / m1_rdata  out  32  read data; valid only while the matching done is high; reset 0.
- m0_done / m1_done  out  1  one-cycle completion pulse; reset 0.
- m0_err / m1_err  out  1  timeout abort flag, qualified by done; reset 0; tied 0 without macro.
- c_cmd  out  3  command to cache, nonzero for the whole transaction; reset 0.
- c_addr  out  ADDR_W  address to cache; reset 0.
- c_wdata  out  32  write data to cache; reset 0.
- c_rdata  in  32  cache read data, valid with `c_ack`.
- c_ack  in  1  cache completion pulse.
- busy  out  1  high in any state other than IDLE; reset 0.
- grant_id  out  1  current or last owner; reset 0.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset enters IDLE, clears all outputs, and sets rr_last = 1 so m0 wins the first tie.
- A request counts only when req = 1 and cmd != 0. req with cmd = 0 is ignored and never granted.
- IDLE: with one valid request, that master wins. With two, the master != rr_last wins. The winner's cmd/addr/wdata are latched into c_cmd/c_addr/c_wdata, grant_id is set, and the FSM goes to ISSUE.
- ISSUE: one cycle in which c_cmd is first presented. Then go to WAIT.
- WAIT: c_* outputs stay frozen, so mid-transaction changes on the master inputs have no effect. On c_ack, capture c_rdata, clear c_cmd to 0, and go to RESP.
- RESP: pulse the owner's done for one cycle. rdata = captured data for reads, 0 for writes and invalidate. Set rr_last = grant_id and go to IDLE.
- The arbiter does not re-sample a master's req in the cycle its done is high. A req still high afterwards is a new request.
- c_ack outside WAIT is ignored.
- The losing master's req stays pending with no timeout of its own. Fairness bound: one transaction.

## Timing
- Cycle 0: req sampled in IDLE. Cycle 1: c_cmd valid (ISSUE). Earliest c_ack sampled in cycle 2. done is high in the cycle after the c_ack is sampled.
- Minimum latency from req to done is 3 cycles. Back-to-back minimum spacing is 4 cycles per grant.
- Asserting reset mid-transaction drops the transaction: c_cmd goes to 0 immediately and no done is issued. Masters must re-request.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- `CACHE_ARB_TIMEOUT_EN` defined: a WAIT-cycle counter, cleared on entry to WAIT. When it reaches TIMEOUT_CYCLES with no c_ack, the arbiter clears c_cmd, goes to RESP, and pulses done with err = 1 and rdata = 0.
- Undefined: no counter, err ports are tied 0, and WAIT lasts indefinitely.

## Structure
- Package `cache_arb_pkg`: command enum (CMD_NONE … CMD_WR32), FSM state enum, and `is_read(cmd)` helper.
- Sub-module `cache_arb_rr`: combinational 2-way round-robin picker (req vector and rr_last in; grant and valid out).
- Everything else (FSM, latches, timeout counter) stays in `cache_port_arbiter`.

## Test plan
- m0 read32 @0x00010, cache acks in cycle 3 with 0xDEADBEEF -> c_cmd=3 during cycles 1–3, m0_done at cycle 4 with m0_rdata=0xDEADBEEF, m1 idle.
- m0 and m1 requesting simultaneously after reset -> m0 granted first, then m1. Both requests held again -> m0 after m1 (alternation over 4 grants).
- m1 write16 0x0000BEEF @0x3FFF2 while m0 changes its addr mid-WAIT -> c_addr stays 0x3FFF2, m1_done with rdata=0, m0 served next with its new addr.
- req=1 with cmd=0 on m0 plus m1 read8 -> only m1 granted, and m0 never gets done.
- Reset asserted in WAIT -> c_cmd=0, busy=0, no done. Post-reset request completes normally.
- With `CACHE_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=8, never ack -> done and err = 1 exactly 8 WAIT cycles after entering WAIT, and the next request proceeds.
